instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer that sits directly upstream of `operation_block`. It fetches 12-bit instructions from a synchronous program ROM and decodes them. For ALU instructions it drives `operation_code`, `in_b` and a single-cycle `aku_enable` pulse into `operation_block`. It also handles jumps, halt and an optional hardware loop counter.

## Interface
- `ADDR_W`, 8: program counter and ROM address width; legal range 1..8.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run`  input  1  sequencing enable; sampled only in FETCH.
- `rom_addr`  output  ADDR_W  program ROM address, equal to `pc`.
- `rom_data`  input  12  ROM read data, valid one cycle after `rom_addr` is presented.
- `operation_code`  output  3  ALU operation, connects to `operation_block.operation_code`.
- `in_b`  output  8  ALU operand B, connects to `operation_block.in_b`.
- `aku_enable`  output  1  accumulator/carry write strobe, connects to `operation_block.aku_enable`.
- `halted`  output  1  high once a HALT instruction has executed.

## Operation
- Instruction format: `[11:8]` opcode, `[7:0]` imm.
  - 0x0–0x7 ALU: `operation_code <= op[2:0]`, `in_b <= imm`, pulse `aku_enable`, `pc+1`.
  - 0x8 NOP: `pc+1`.
  - 0x9 JMP: `pc <= imm[ADDR_W-1:0]`.
  - 0xA HALT: enter HALTED; `pc` unchanged.
  - 0xB LOOP: if `loop_cnt != 0`, then `loop_cnt <= loop_cnt-1` and `pc <= imm[ADDR_W-1:0]`; else `pc+1`.
  - 0xC LDC: `loop_cnt <= imm`, `pc+1`.
  - 0xD–0xF are reserved and execute as NOP.
- State machine: FETCH → DECODE → EXECUTE → FETCH; any → HALTED on HALT.
  - FETCH: `rom_addr = pc`. Advance to DECODE only if `run = 1`; otherwise stay.
  - DECODE: latch `rom_data` into the instruction register.
  - EXECUTE: perform the instruction and update `pc`.
  - HALTED: absorbing. `halted = 1`. Left only by reset.
- `pc` arithmetic is modulo 2^ADDR_W. `pc+1` at all-ones wraps to 0.
- `operation_code` and `in_b` are registered. They change only in EXECUTE of an ALU instruction and hold otherwise, including through NOP/JMP/HALT.
- `run` deasserted mid-instruction (DECODE/EXECUTE) does not abort; the instruction completes and the sequencer stalls in the next FETCH.
- Reset values:
  - `pc = 0`, state FETCH, `rom_addr = 0`.
  - `operation_code = 0`, `in_b = 0`, `aku_enable = 0`, `halted = 0`, `loop_cnt = 0`.
- Reset asserted mid-instruction discards the instruction immediately; no `aku_enable` pulse may escape.

## Timing
- Every instruction takes 3 cycles when `run` is held high.
- `aku_enable` is high for exactly one cycle, the EXECUTE cycle of an ALU instruction.
- `operation_code` and `in_b` are valid in that same cycle. The accumulator captures on the rising edge that ends EXECUTE.
- `rom_data` is sampled at the edge ending DECODE, which is one cycle after `rom_addr` became valid in FETCH.
- `halted` rises the cycle after EXECUTE of HALT.
- Outputs are glitch-free register outputs, except `rom_addr`, which is a direct copy of the `pc` register.

## Configuration
- `SEQ_LOOP_EN` defined: the 8-bit `loop_cnt` register and the LOOP/LDC semantics above are compiled in.
- `SEQ_LOOP_EN` undefined: `loop_cnt` is absent; 0xB and 0xC execute as NOP (`pc+1`).

## Test plan
- Reset with ROM[0] = 0x30A: after `rst_n` rises and `run = 1`, `aku_enable` pulses exactly once at cycle 3 with `operation_code = 3` and `in_b = 0x0A`. The pulse is absent while `rst_n = 0`.
- ROM = {0x105, 0x904, …, [4] = 0xA00}: `rom_addr` sequence is 0,1,4. `halted = 1` after the HALT EXECUTE. `pc` stays 4 for 20 further cycles and `aku_enable` stays 0.
- Loop (`SEQ_LOOP_EN`): ROM = {0xC03, 0x201, 0xB01, 0xA00}. `aku_enable` pulses 4 times with `operation_code = 2`, `in_b = 1`; ends halted at `pc = 3`. Same ROM without the macro: exactly 1 pulse.
- Wrap: ADDR_W = 2, ROM = {0x800, 0x800, 0x800, 0x800}. `rom_addr` cycles 0,1,2,3,0 with no halt.
- `run` dropped during the DECODE of an ALU instruction: that instruction still pulses `aku_enable`. The sequencer holds in FETCH with `rom_addr = pc+1` until `run` returns, then resumes.
- Async reset asserted during EXECUTE: all outputs return to reset values within the same cycle with no clock edge required. Fetch then restarts at `rom_addr = 0`.

Source files
------------

// File: rtl/instr_sequencer.sv
// Three-cycle fetch/decode/execute program sequencer driving operation_block.
// Define SEQ_LOOP_EN to compile in the 8-bit hardware loop counter (LDC/LOOP).
module instr_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [2:0]        operation_code,
  output logic [7:0]        in_b,
  output logic              aku_enable,
  output logic              halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;
  localparam logic [3:0] OP_LOOP = 4'hB;
  localparam logic [3:0] OP_LDC  = 4'hC;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc_s, target_s;
  logic [11:0]       ir_q, ir_d;
  logic [2:0]        op_q, op_d;
  logic [7:0]        in_b_q, in_b_d;
  logic              aku_q, aku_d;
  logic              halted_q, halted_d;
`ifdef SEQ_LOOP_EN
  logic [7:0]        loop_q, loop_d;
`endif

  assign pc_inc_s = pc_q + ADDR_W'(1'b1);
  assign target_s = ADDR_W'(ir_q[7:0]);

  // Next-state and datapath decode for the sequencer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    op_d     = op_q;
    in_b_d   = in_b_q;
    aku_d    = 1'b0;
    halted_d = halted_q;
`ifdef SEQ_LOOP_EN
    loop_d   = loop_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (run) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU operands are loaded here so they are already valid during EXECUTE.
        ir_d    = rom_data;
        state_d = S_EXEC;
        if (!rom_data[11]) begin
          aku_d  = 1'b1;
          op_d   = rom_data[10:8];
          in_b_d = rom_data[7:0];
        end else begin
          aku_d  = 1'b0;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[11:8])
          OP_JMP: pc_d = target_s;
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
`ifdef SEQ_LOOP_EN
          OP_LOOP: begin
            if (loop_q != 8'd0) begin
              loop_d = loop_q - 8'd1;
              pc_d   = target_s;
            end else begin
              pc_d   = pc_inc_s;
            end
          end
          OP_LDC: begin
            loop_d = ir_q[7:0];
            pc_d   = pc_inc_s;
          end
`endif
          default: pc_d = pc_inc_s;
        endcase
      end
      S_HALT: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and output registers; reset clears everything so no strobe can escape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= 12'h000;
      op_q     <= 3'd0;
      in_b_q   <= 8'd0;
      aku_q    <= 1'b0;
      halted_q <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      op_q     <= op_d;
      in_b_q   <= in_b_d;
      aku_q    <= aku_d;
      halted_q <= halted_d;
`ifdef SEQ_LOOP_EN
      loop_q   <= loop_d;
`endif
    end
  end

  assign rom_addr       = pc_q;
  assign operation_code = op_q;
  assign in_b           = in_b_q;
  assign aku_enable     = aku_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized and directed bench for instr_sequencer against an instruction-level model.
module tb_instr_sequencer;

  localparam int AW = 8;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data = 12'h000;
  logic [2:0]    op;
  logic [7:0]    inb;
  logic          aku, halted;

  logic [1:0]    rom_addr2;
  logic [11:0]   rom_data2;
  logic [2:0]    op2;
  logic [7:0]    inb2;
  logic          aku2, halted2;

  logic [11:0]   rom [256];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  // Synchronous program ROMs: data appears one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];
  assign rom_data2 = 12'h800;

  instr_sequencer #(.ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .operation_code(op), .in_b(inb), .aku_enable(aku), .halted(halted));

  instr_sequencer #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run(1'b1), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .operation_code(op2), .in_b(inb2), .aku_enable(aku2), .halted(halted2));

  // Instruction-level reference: each instruction occupies phases 0,1,2 of its slot.
  int          m_pc, m_loop, m_phase, t2;
  logic [11:0] m_ir;
  logic        m_halt, m_aku;
  logic [2:0]  m_op;
  logic [7:0]  m_inb;

  function automatic int next_pc(int pc, logic [11:0] ir, int lc);
    int opc = int'(ir[11:8]);
    int imm = int'(ir[7:0]);
    if (opc == 9) return imm % (1 << AW);
    if (opc == 10) return pc;
    if (opc == 11 && LOOP_EN && lc != 0) return imm % (1 << AW);
    return (pc + 1) % (1 << AW);
  endfunction

  function automatic int next_loop(logic [11:0] ir, int lc);
    if (LOOP_EN && ir[11:8] == 4'hC) return int'(ir[7:0]);
    if (LOOP_EN && ir[11:8] == 4'hB && lc != 0) return lc - 1;
    return lc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_loop <= 0; m_phase <= 0; m_ir <= 12'h000; t2 <= 0;
      m_halt <= 1'b0; m_aku <= 1'b0; m_op <= 3'd0; m_inb <= 8'd0;
    end else begin
      t2    <= t2 + 1;
      m_aku <= 1'b0;
      if (m_phase == 0) begin
        if (!m_halt && run) begin
          m_ir    <= rom[m_pc];
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
        if (m_ir < 12'h800) begin
          m_aku <= 1'b1;
          m_op  <= m_ir[10:8];
          m_inb <= m_ir[7:0];
        end
      end else begin
        m_phase <= 0;
        m_pc    <= next_pc(m_pc, m_ir, m_loop);
        m_loop  <= next_loop(m_ir, m_loop);
        m_halt  <= (m_ir[11:8] == 4'hA);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp();
    chk("rom_addr", int'(rom_addr), m_pc);
    chk("aku_enable", int'(aku), int'(m_aku));
    chk("operation_code", int'(op), int'(m_op));
    chk("in_b", int'(inb), int'(m_inb));
    chk("halted", int'(halted), int'(m_halt));
    chk("wrap_rom_addr", int'(rom_addr2), (t2 / 3) % 4);
    chk("wrap_no_halt", int'(halted2), 0);
    chk("wrap_no_aku", int'(aku2), 0);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
  endtask

  task automatic load_all(input logic [11:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  int pulses, bad, exp_pulses;

  initial begin
    load_all(12'hA00);
    run = 1'b1;

    // Reset pulse check, then single ALU pulse at cycle 3.
    rst_n = 1'b0;
    rom[0] = 12'h30A;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (aku) pulses++;
    end
    chk("aku_during_reset", pulses, 0);
    rst_n = 1'b1;
    tick();
    chk("t1_c2_aku", int'(aku), 0);
    tick();
    chk("t1_c3_aku", int'(aku), 1);
    chk("t1_c3_op", int'(op), 3);
    chk("t1_c3_inb", int'(inb), 10);
    pulses = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (aku) pulses++;
    end
    chk("t1_pulse_count", pulses, 1);

    // Jump then halt, plus the ADDR_W=2 wrap instance.
    rst_n = 1'b0;
    load_all(12'hA00);
    rom[0] = 12'h105; rom[1] = 12'h904; rom[2] = 12'h2FF; rom[3] = 12'h2FF; rom[4] = 12'hA00;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("t2_c1_addr", int'(rom_addr), 0);
    tick(); tick(); tick();
    chk("t2_c4_addr", int'(rom_addr), 1);
    chk("t4_c4_addr", int'(rom_addr2), 1);
    tick(); tick(); tick();
    chk("t2_c7_addr", int'(rom_addr), 4);
    chk("t4_c7_addr", int'(rom_addr2), 2);
    tick(); tick();
    chk("t2_c9_halted", int'(halted), 0);
    tick();
    chk("t2_c10_halted", int'(halted), 1);
    chk("t4_c10_addr", int'(rom_addr2), 3);
    tick(); tick(); tick();
    chk("t4_c13_addr", int'(rom_addr2), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rom_addr != 8'd4 || aku || !halted) bad++;
    end
    chk("t2_halt_hold", bad, 0);

    // Hardware loop program.
    rst_n = 1'b0;
    load_all(12'hA00);
    rom[0] = 12'hC03; rom[1] = 12'h201; rom[2] = 12'hB01; rom[3] = 12'hA00;
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      tick();
      if (aku) begin
        pulses++;
        if (op != 3'd2 || inb != 8'd1) bad++;
      end
    end
    exp_pulses = LOOP_EN ? 4 : 1;
    chk("t3_pulses", pulses, exp_pulses);
    chk("t3_operands", bad, 0);
    chk("t3_halted", int'(halted), 1);
    chk("t3_final_pc", int'(rom_addr), 3);

    // run dropped during DECODE of an ALU instruction.
    rst_n = 1'b0;
    load_all(12'hA00);
    rom[0] = 12'h123; rom[1] = 12'h145; rom[2] = 12'hA00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run = 1'b0;
    tick();
    chk("t5_c3_aku", int'(aku), 1);
    chk("t5_c3_op", int'(op), 1);
    chk("t5_c3_inb", int'(inb), 8'h23);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (aku) pulses++;
    end
    chk("t5_stall_pulses", pulses, 0);
    chk("t5_stall_addr", int'(rom_addr), 1);
    run = 1'b1;
    tick(); tick();
    chk("t5_resume_aku", int'(aku), 1);
    chk("t5_resume_inb", int'(inb), 8'h45);

    // Asynchronous reset in the middle of EXECUTE.
    rst_n = 1'b0;
    load_all(12'hA00);
    rom[0] = 12'h800; rom[1] = 12'h7FF;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_exec_aku", int'(aku), 1);
    chk("t6_exec_op", int'(op), 7);
    chk("t6_exec_addr", int'(rom_addr), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_aku", int'(aku), 0);
    chk("t6_async_op", int'(op), 0);
    chk("t6_async_inb", int'(inb), 0);
    chk("t6_async_addr", int'(rom_addr), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_restart_addr", int'(rom_addr), 1);

    // Random programs with random run gaps.
    for (int ep = 0; ep < 8; ep++) begin
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
        int o;
        int imm;
        o = $urandom_range(0, 15);
        imm = $urandom_range(0, 255);
        if (o == 10 && $urandom_range(0, 3) != 0) o = 8;
        if (o == 12) imm = $urandom_range(0, 5);
        rom[i] = {o[3:0], imm[7:0]};
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 250; c++) begin
        run = ($urandom_range(0, 9) != 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
